// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the asynchronous FIFO: the default RAM address
//   width, the pointer width with its wrap bit, the FIFO depth, and the
//   pointer type. The write controller and the pointer synchroniser use
//   these definitions too.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_W = 4;
    localparam int unsigned FIFO_PTR_W  = FIFO_ADDR_W + 1;
    localparam int unsigned FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

    typedef logic [FIFO_PTR_W-1:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-side controller of the asynchronous FIFO, in the read clock domain.
//   It owns the binary read pointer, drives the RAM read address, and derives
//   the empty, almost_empty, occupancy and sticky underflow status from the
//   write pointer. The write pointer arrives already synchronised and
//   converted to binary.
//
// Ports
//   clk          in   read-domain clock, rising edge
//   reset        in   asynchronous, active-high reset
//   rd_en        in   read request from the consumer
//   wptr_sync    in   synchronised binary write pointer (PTR_W)
//   rd_addr      out  RAM read address, low bits of the read pointer (ADDR_W)
//   rd_ptr       out  registered binary read pointer, to the write domain
//   rd_valid     out  RAM read data valid this cycle (one cycle after accept)
//   empty        out  registered empty flag
//   almost_empty out  registered, occupancy <= AE_THRESH
//   rd_count     out  registered occupancy, 0..2**ADDR_W
//   underflow    out  sticky: rd_en seen while empty, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W    = FIFO_ADDR_W,
    parameter int unsigned PTR_W     = ADDR_W + 1,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  wptr_sync,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [PTR_W-1:0]  rd_count,
    output logic              underflow
);

    localparam logic [PTR_W-1:0] DEPTH_P     = PTR_W'(1) << ADDR_W;
    localparam logic [PTR_W-1:0] AE_THRESH_P = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] rd_count_q, rd_count_d;
    logic             empty_q,    empty_d;
    logic             ae_q,       ae_d;
    logic             valid_q,    valid_d;
    logic             under_q,    under_d;
    logic             accept;

    // Status is computed from the post-read pointer, so the edge that takes
    // the last entry also raises empty; a write seen in the same cycle folds
    // into the same subtraction without any priority logic.
    always_comb begin
        accept     = rd_en && !empty_q;
        rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, accept};
        rd_count_d = wptr_sync - rd_ptr_d;
        empty_d    = (wptr_sync == rd_ptr_d);
        ae_d       = (rd_count_d <= AE_THRESH_P);
        valid_d    = accept;
        under_d    = under_q || (rd_en && empty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            rd_count_q <= '0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            valid_q    <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_count_q <= rd_count_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            valid_q    <= valid_d;
            under_q    <= under_d;
        end
    end

    // An occupancy above the FIFO depth can only come from a write-side
    // fault; this block flags it in simulation and otherwise ignores it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (rd_count_d <= DEPTH_P);
        end
    end

    assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign rd_ptr       = rd_ptr_q;
    assign rd_valid     = valid_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_count     = rd_count_q;
    assign underflow    = under_q;

endmodule : fifo_rd_ctrl
